// File: rtl/vfaddsub_if.sv
// Handshake and VRF/FPU bus for the vfadd/vfsub element sequencer.
// Flag outputs exist only when VFADDSUB_FLAGS_EN is defined.
interface vfaddsub_if #(
   parameter int REG_W  = 5,
   parameter int IDX_W  = 5,
   parameter int DATA_W = 32
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_sub;
   logic [IDX_W:0]         cmd_vl;
   logic [REG_W-1:0]       cmd_vs1;
   logic [REG_W-1:0]       cmd_vs2;
   logic [REG_W-1:0]       cmd_vd;
   logic                   rd_en;
   logic [REG_W+IDX_W-1:0] rd_addr_a;
   logic [REG_W+IDX_W-1:0] rd_addr_b;
   logic [DATA_W-1:0]      rd_data_a;
   logic [DATA_W-1:0]      rd_data_b;
   logic [DATA_W-1:0]      fpu_a;
   logic [DATA_W-1:0]      fpu_b;
   logic                   fpu_sub;
   logic [DATA_W-1:0]      fpu_y;
   logic                   wr_en;
   logic [REG_W+IDX_W-1:0] wr_addr;
   logic [DATA_W-1:0]      wr_data;
   logic                   busy;
   logic                   done;
`ifdef VFADDSUB_FLAGS_EN
   logic                   flag_nv;
   logic                   flag_of;
`endif

   modport slave (
      input  cmd_valid, cmd_sub, cmd_vl, cmd_vs1, cmd_vs2, cmd_vd,
      input  rd_data_a, rd_data_b, fpu_y,
      output cmd_ready, rd_en, rd_addr_a, rd_addr_b,
      output fpu_a, fpu_b, fpu_sub,
      output wr_en, wr_addr, wr_data, busy, done
`ifdef VFADDSUB_FLAGS_EN
      , output flag_nv, flag_of
`endif
   );

   modport master (
      output cmd_valid, cmd_sub, cmd_vl, cmd_vs1, cmd_vs2, cmd_vd,
      output rd_data_a, rd_data_b, fpu_y,
      input  cmd_ready, rd_en, rd_addr_a, rd_addr_b,
      input  fpu_a, fpu_b, fpu_sub,
      input  wr_en, wr_addr, wr_data, busy, done
`ifdef VFADDSUB_FLAGS_EN
      , input flag_nv, flag_of
`endif
   );
endinterface

// File: rtl/vfaddsub_seq.sv
// Element sequencer for vector FP add/sub: read -> fp_addsub -> write, 1 elem/cycle.
// Optional sticky NV/OF flags when VFADDSUB_FLAGS_EN is defined.
module vfaddsub_seq #(
   parameter int REG_W  = 5,
   parameter int IDX_W  = 5,
   parameter int DATA_W = 32
) (
   input logic       clk,
   input logic       reset,
   vfaddsub_if.slave bus
);
   localparam int AW = REG_W + IDX_W;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e            state_q, state_d;
   logic [IDX_W:0]    vl_q, vl_d;
   logic [IDX_W:0]    cnt_q, cnt_d;
   logic              sub_q, sub_d;
   logic [REG_W-1:0]  vs1_q, vs1_d;
   logic [REG_W-1:0]  vs2_q, vs2_d;
   logic [REG_W-1:0]  vd_q, vd_d;
   logic              rd_en_q, rd_en_d;
   logic [AW-1:0]     rd_addr_a_q, rd_addr_a_d;
   logic [AW-1:0]     rd_addr_b_q, rd_addr_b_d;
   logic              v1_q, v1_d;
   logic [IDX_W-1:0]  idx1_q, idx1_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic              opsub_q, opsub_d;
   logic              wr_en_q, wr_en_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rdy_q, rdy_d;
   logic              accept;
   logic [DATA_W-1:0] op_a, op_b;
   logic              op_sub;

   assign accept = bus.cmd_valid & rdy_q;

   // Operands pass straight through while an element is in flight, else hold.
   assign op_a   = v1_q ? bus.rd_data_a : opa_q;
   assign op_b   = v1_q ? bus.rd_data_b : opb_q;
   assign op_sub = v1_q ? sub_q : opsub_q;

   always_comb begin
      state_d     = state_q;
      vl_d        = vl_q;
      cnt_d       = cnt_q;
      sub_d       = sub_q;
      vs1_d       = vs1_q;
      vs2_d       = vs2_q;
      vd_d        = vd_q;
      rd_en_d     = 1'b0;
      rd_addr_a_d = rd_addr_a_q;
      rd_addr_b_d = rd_addr_b_q;
      v1_d        = rd_en_q;
      idx1_d      = rd_addr_a_q[IDX_W-1:0];
      opa_d       = op_a;
      opb_d       = op_b;
      opsub_d     = op_sub;
      wr_en_d     = v1_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      if (v1_q) begin
         wr_addr_d = {vd_q, idx1_q};
         wr_data_d = bus.fpu_y;
      end
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               vl_d  = bus.cmd_vl;
               sub_d = bus.cmd_sub;
               vs1_d = bus.cmd_vs1;
               vs2_d = bus.cmd_vs2;
               vd_d  = bus.cmd_vd;
               if (bus.cmd_vl == '0) begin
                  state_d = DONE;
               end else begin
                  state_d     = RUN;
                  rd_en_d     = 1'b1;
                  rd_addr_a_d = {bus.cmd_vs1, {IDX_W{1'b0}}};
                  rd_addr_b_d = {bus.cmd_vs2, {IDX_W{1'b0}}};
                  cnt_d       = {{IDX_W{1'b0}}, 1'b1};
               end
            end
         end
         RUN: begin
            // cnt is one wider than an index so vl = MAX_VL terminates
            if (cnt_q == vl_q) begin
               state_d = DRAIN;
            end else begin
               rd_en_d     = 1'b1;
               rd_addr_a_d = {vs1_q, cnt_q[IDX_W-1:0]};
               rd_addr_b_d = {vs2_q, cnt_q[IDX_W-1:0]};
               cnt_d       = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (wr_en_q && !v1_q) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
      rdy_d  = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         vl_q        <= '0;
         cnt_q       <= '0;
         sub_q       <= 1'b0;
         vs1_q       <= '0;
         vs2_q       <= '0;
         vd_q        <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
         v1_q        <= 1'b0;
         idx1_q      <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         opsub_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rdy_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         vl_q        <= vl_d;
         cnt_q       <= cnt_d;
         sub_q       <= sub_d;
         vs1_q       <= vs1_d;
         vs2_q       <= vs2_d;
         vd_q        <= vd_d;
         rd_en_q     <= rd_en_d;
         rd_addr_a_q <= rd_addr_a_d;
         rd_addr_b_q <= rd_addr_b_d;
         v1_q        <= v1_d;
         idx1_q      <= idx1_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         opsub_q     <= opsub_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rdy_q       <= rdy_d;
      end
   end

`ifdef VFADDSUB_FLAGS_EN
   logic nv_q, nv_d;
   logic of_q, of_d;
   logic y_ff, a_ff, b_ff;

   assign y_ff = &bus.fpu_y[30:23];
   assign a_ff = &op_a[30:23];
   assign b_ff = &op_b[30:23];

   always_comb begin
      nv_d = nv_q;
      of_d = of_q;
      if (accept) begin
         nv_d = 1'b0;
         of_d = 1'b0;
      end else if (v1_q && y_ff) begin
         if (|bus.fpu_y[22:0]) nv_d = 1'b1;
         else if (!a_ff && !b_ff) of_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         nv_q <= 1'b0;
         of_q <= 1'b0;
      end else begin
         nv_q <= nv_d;
         of_q <= of_d;
      end
   end

   assign bus.flag_nv = nv_q;
   assign bus.flag_of = of_q;
`endif

   assign bus.cmd_ready = rdy_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr_a = rd_addr_a_q;
   assign bus.rd_addr_b = rd_addr_b_q;
   assign bus.fpu_a     = op_a;
   assign bus.fpu_b     = op_b;
   assign bus.fpu_sub   = op_sub;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_vfaddsub_seq.sv
// Randomized bench for vfaddsub_seq with a VRF model and a real-valued FP add model.
// Define VFADDSUB_FLAGS_EN to also check the sticky flags.
module tb_vfaddsub_seq;
   localparam int REG_W  = 5;
   localparam int IDX_W  = 5;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vfaddsub_if #(.REG_W(REG_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

   vfaddsub_seq #(.REG_W(REG_W), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] mem [0:1023];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic real to_real(input logic [31:0] x);
      real m;
      int  e;
      if (x[30:23] == 8'd0) return 0.0;
      m = 1.0 + real'(x[22:0]) / 8388608.0;
      e = int'(x[30:23]) - 127;
      m = m * (2.0 ** e);
      return x[31] ? -m : m;
   endfunction

   function automatic logic [31:0] from_real(input real r);
      logic        s;
      real         m;
      int          e;
      logic [22:0] f;
      s = (r < 0.0);
      m = s ? -r : r;
      e = 0;
      if (m == 0.0) return {s, 31'd0};
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      if (e > 127) return {s, 8'hFF, 23'd0};
      if (e < -126) return {s, 31'd0};
      f = 23'($rtoi((m - 1.0) * 8388608.0));
      return {s, 8'(e + 127), f};
   endfunction

   // Stand-in for fp_addsub: IEEE specials explicit, finite values via real math.
   function automatic logic [31:0] fp_model(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic sub);
      logic [31:0] bb;
      logic an, bn, ai, bi;
      bb = {b[31] ^ sub, b[30:0]};
      an = (&a[30:23]) & (|a[22:0]);
      bn = (&b[30:23]) & (|b[22:0]);
      ai = (&a[30:23]) & ~(|a[22:0]);
      bi = (&b[30:23]) & ~(|b[22:0]);
      if (an || bn) return 32'h7FC00000;
      if (ai && bi) return (a[31] != bb[31]) ? 32'h7FC00000 : a;
      if (ai) return a;
      if (bi) return bb;
      return from_real(to_real(a) + to_real(bb));
   endfunction

   assign bus.fpu_y = fp_model(bus.fpu_a, bus.fpu_b, bus.fpu_sub);

   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.rd_data_a <= mem[bus.rd_addr_a];
         bus.rd_data_b <= mem[bus.rd_addr_b];
      end
   end

   task automatic fill_mem();
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
   endtask

   task automatic run(input logic sub, input int vl, input logic [4:0] vs1,
                      input logic [4:0] vs2, input logic [4:0] vd,
                      input int rst_at, input bit hold);
      logic [31:0] eq_d [$];
      logic [9:0]  eq_a [$];
      int          eq_c [$];
      logic [31:0] a, b, y;
      bit e_nv, e_of, got_done;
      int k, rd_n, post, done_exp;
      e_nv = 0; e_of = 0; got_done = 0; rd_n = 0; post = 0;
      for (int i = 0; i < vl; i++) begin
         a = mem[{vs1, 5'(i)}];
         b = mem[{vs2, 5'(i)}];
         y = fp_model(a, b, sub);
         eq_d.push_back(y);
         eq_a.push_back({vd, 5'(i)});
         eq_c.push_back(i + 3);
         if (&y[30:23]) begin
            if (|y[22:0]) e_nv = 1;
            else if (!(&a[30:23]) && !(&b[30:23])) e_of = 1;
         end
      end
      done_exp = (vl == 0) ? 1 : vl + 3;
      @(negedge clk);
      chk("rdy_idle", 64'(bus.cmd_ready), 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_sub   = sub;
      bus.cmd_vl    = 6'(vl);
      bus.cmd_vs1   = vs1;
      bus.cmd_vs2   = vs2;
      bus.cmd_vd    = vd;
      @(posedge clk);
      k = 0;
      while (k < done_exp + 4) begin
         @(negedge clk);
         k++;
         bus.cmd_valid = hold && (k < done_exp);
         bus.cmd_sub   = ~sub;
         bus.cmd_vl    = 6'($urandom);
         bus.cmd_vs1   = 5'($urandom);
         bus.cmd_vs2   = 5'($urandom);
         bus.cmd_vd    = 5'($urandom);
`ifdef VFADDSUB_FLAGS_EN
         if (k == 1) begin
            chk("nv_clr", 64'(bus.flag_nv), 0);
            chk("of_clr", 64'(bus.flag_of), 0);
         end
`endif
         if (rst_at != 0 && k > rst_at) begin
            if (bus.wr_en || bus.done || bus.rd_en) post++;
            if (k == rst_at + 1) begin
               chk("rst_busy", 64'(bus.busy), 0);
               chk("rst_rdy", 64'(bus.cmd_ready), 1);
               reset = 1'b0;
            end
         end else begin
            if (rst_at != 0 && k == rst_at) reset = 1'b1;
            if (bus.rd_en) rd_n++;
            if (bus.wr_en) begin
               if (eq_c.size() == 0) begin
                  chk("wr_extra", 1, 0);
               end else begin
                  chk("wr_cyc", 64'(k), 64'(eq_c.pop_front()));
                  chk("wr_addr", 64'(bus.wr_addr), 64'(eq_a.pop_front()));
                  chk("wr_data", 64'(bus.wr_data), 64'(eq_d.pop_front()));
               end
            end
            if (bus.done && rst_at == 0) begin
               chk("done_cyc", 64'(k), 64'(done_exp));
               got_done = 1;
`ifdef VFADDSUB_FLAGS_EN
               chk("flag_nv", 64'(bus.flag_nv), 64'(e_nv));
               chk("flag_of", 64'(bus.flag_of), 64'(e_of));
`endif
            end
            if (rst_at == 0 && k == done_exp + 1) begin
               chk("rdy_back", 64'(bus.cmd_ready), 1);
               chk("busy_off", 64'(bus.busy), 0);
            end
         end
      end
      bus.cmd_valid = 1'b0;
      if (rst_at == 0) begin
         chk("wr_left", 64'(eq_c.size()), 0);
         chk("rd_cnt", 64'(rd_n), 64'(vl));
         chk("done_seen", 64'(got_done), 1);
      end else begin
         chk("rst_quiet", 64'(post), 0);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_sub   = 1'b0;
      bus.cmd_vl    = '0;
      bus.cmd_vs1   = '0;
      bus.cmd_vs2   = '0;
      bus.cmd_vd    = '0;
      fill_mem();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(bus.cmd_ready), 1);
      chk("rst_busy0", 64'(bus.busy), 0);
      chk("rst_done0", 64'(bus.done), 0);
      chk("rst_rd_en", 64'(bus.rd_en), 0);
      chk("rst_wr_en", 64'(bus.wr_en), 0);
      chk("rst_wr_addr", 64'(bus.wr_addr), 0);
      chk("rst_wr_data", 64'(bus.wr_data), 0);
      chk("rst_rd_addr", 64'(bus.rd_addr_a), 0);
      reset = 1'b0;

      mem[{5'd1, 5'd0}] = 32'h3F800000;
      mem[{5'd2, 5'd0}] = 32'h40000000;
      run(1'b0, 1, 5'd1, 5'd2, 5'd4, 0, 0);

      mem[{5'd5, 5'd0}] = 32'h40400000;
      mem[{5'd5, 5'd1}] = 32'h40A00000;
      mem[{5'd5, 5'd2}] = 32'h3F800000;
      mem[{5'd5, 5'd3}] = 32'h41200000;
      for (int i = 0; i < 4; i++) mem[{5'd6, 5'(i)}] = 32'h3F800000;
      run(1'b1, 4, 5'd5, 5'd6, 5'd7, 0, 0);
      chk("sub_e3", 64'(mem[{5'd7, 5'd3}] == 32'h0), 0);

      run(1'b0, 0, 5'd8, 5'd9, 5'd10, 0, 0);
      run(1'b0, 32, 5'd11, 5'd12, 5'd3, 0, 1);
      run(1'b1, 16, 5'd13, 5'd14, 5'd15, 5, 0);

`ifdef VFADDSUB_FLAGS_EN
      mem[{5'd16, 5'd0}] = 32'h7F7FFFFF;
      mem[{5'd16, 5'd1}] = 32'h7F800000;
      mem[{5'd17, 5'd0}] = 32'h7F7FFFFF;
      mem[{5'd17, 5'd1}] = 32'hFF800000;
      run(1'b0, 2, 5'd16, 5'd17, 5'd18, 0, 0);
      mem[{5'd19, 5'd0}] = 32'h3F800000;
      mem[{5'd20, 5'd0}] = 32'h3F800000;
      run(1'b0, 1, 5'd19, 5'd20, 5'd21, 0, 0);
`endif

      for (int t = 0; t < 12; t++) begin
         if (t % 4 == 0) fill_mem();
         run(1'($urandom_range(0, 1)), int'($urandom_range(0, 32)),
             5'($urandom), 5'($urandom), 5'($urandom), 0,
             bit'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
